// File: rtl/riscv_next_strategy_ras_jump.sv
// ID-stage next-PC strategy: injects direct-jump targets and predicts returns
// from a circular return-address stack that is pushed on calls and popped on returns.
module riscv_next_strategy_ras_jump #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned RAS_DEPTH  = 8,
    parameter int unsigned CNT_WIDTH  = $clog2(RAS_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  enable,
    input  logic                  i_id_valid,
    input  logic                  i_id_flush,
    input  logic [ADDR_WIDTH-1:0] i_id_pc,
    input  logic [ADDR_WIDTH-1:0] i_id_imm,
    input  logic                  i_id_compressed,
    input  logic                  i_id_jal,
    input  logic                  i_id_jalr,
    input  logic [4:0]            i_id_rd,
    input  logic [4:0]            i_id_rs1,
    input  logic                  i_ex_mispredict,
    output logic                  o_inject,
    output logic [ADDR_WIDTH-1:0] o_inject_addr,
    output logic [CNT_WIDTH-1:0]  o_ras_count
);

    localparam int unsigned PTR_WIDTH = $clog2(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_d [RAS_DEPTH];
    logic [PTR_WIDTH-1:0]  tp_q;
    logic [PTR_WIDTH-1:0]  tp_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;

    logic                  act;
    logic                  rd_link;
    logic                  rs1_link;
    logic                  call;
    logic                  ret;
    logic                  ras_nonempty;
    logic                  ras_full;
    logic                  do_push;
    logic                  do_pop;
    logic [ADDR_WIDTH-1:0] link_addr;
    logic [ADDR_WIDTH-1:0] jal_target;

    // Instruction classification following the RISC-V link-register hint table
    always_comb begin
        act          = i_id_valid && !i_id_flush;
        rd_link      = (i_id_rd == 5'd1) || (i_id_rd == 5'd5);
        rs1_link     = (i_id_rs1 == 5'd1) || (i_id_rs1 == 5'd5);
        call         = act && (i_id_jal || i_id_jalr) && rd_link;
        ret          = act && i_id_jalr && rs1_link && !(rd_link && (i_id_rd == i_id_rs1));
        ras_nonempty = (cnt_q != '0);
        ras_full     = (cnt_q == CNT_WIDTH'(RAS_DEPTH));
        do_pop       = ret && ras_nonempty;
        do_push      = call;
        link_addr    = i_id_pc + (i_id_compressed ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
        jal_target   = i_id_pc + i_id_imm;
    end

    // Zero-latency redirect; the address defaults to the jal target when idle
    always_comb begin
        o_inject      = 1'b0;
        o_inject_addr = jal_target;
        o_ras_count   = cnt_q;
        if (act && i_id_jal) begin
            o_inject = 1'b1;
        end else if (act && i_id_jalr && (i_id_rs1 == 5'd0)) begin
            o_inject      = 1'b1;
            o_inject_addr = i_id_imm;
        end else if (do_pop) begin
            o_inject      = 1'b1;
            o_inject_addr = mem_q[tp_q];
        end
    end

    // Stack update; a mispredict only drops the count so tp and entries stay put
    always_comb begin
        tp_d  = tp_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (enable) begin
            if (i_ex_mispredict) begin
                cnt_d = '0;
            end else if (do_pop && do_push) begin
                mem_d[tp_q] = link_addr;
            end else if (do_pop) begin
                tp_d  = tp_q - PTR_WIDTH'(1);
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end else if (do_push) begin
                tp_d        = tp_q + PTR_WIDTH'(1);
                mem_d[tp_d] = link_addr;
                cnt_d       = ras_full ? cnt_q : cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: doc/riscv_next_strategy_ras_jump.md
# riscv_next_strategy_ras_jump

Next-generation ID-stage next-PC strategy for the jump predictor. It injects targets for direct jumps, which are JAL and JALR with rs1 = x0. It also predicts function returns from a parametrised return-address stack (RAS) that is pushed on calls and popped on returns. It sits beside the other next-PC strategies and drives the fetch redirect (inject) path from the decode stage.

## Interface
- ADDR_WIDTH, 64, width of PCs and injected address
- RAS_DEPTH, 8, RAS entries; power of two, ≥2
- CNT_WIDTH, $clog2(RAS_DEPTH)+1, width of occupancy count
- clk  in  1  clock; all state updates on rising edge
- nreset  in  1  asynchronous, active-low reset
- enable  in  1  global stall-gate; state updates only when high
- i_id_valid  in  1  ID holds a valid instruction
- i_id_flush  in  1  ID instruction is being flushed
- i_id_pc  in  ADDR_WIDTH  PC of ID instruction
- i_id_imm  in  ADDR_WIDTH  sign-extended immediate
- i_id_compressed  in  1  instruction is 16-bit (link = pc+2, else pc+4)
- i_id_jal, i_id_jalr  in  1 each  decoded jump type
- i_id_rd, i_id_rs1  in  5 each  register indices
- i_ex_mispredict  in  1  later stage detected a wrong redirect; RAS is cleared
- o_inject  out  1  redirect fetch this cycle
- o_inject_addr  out  ADDR_WIDTH  redirect target
- o_ras_count  out  CNT_WIDTH  valid RAS entries, 0..RAS_DEPTH

## Operation
- Link register: index 1 or 5. act = i_id_valid && !i_id_flush.
- call = act && (jal || jalr) && link(rd).
- ret = act && jalr && link(rs1) && !(link(rd) && rd==rs1).
- Push/pop actions follow the RISC-V hint table:
  - ret only: pop.
  - call only: push.
  - jalr with both rd and rs1 link and rd≠rs1: pop then push in the same cycle. The top entry is replaced; the count is unchanged.
  - rd==rs1==link: push only.
- Push value: i_id_pc + (i_id_compressed ? 2 : 4), truncated to ADDR_WIDTH.
- Inject priority, evaluated combinationally:
  1. jal: target = i_id_pc + i_id_imm, signed, mod 2^ADDR_WIDTH.
  2. jalr with rs1==0: target = i_id_imm.
  3. ret with o_ras_count>0: target = top entry. If the count is 0, no inject and no pop.
  4. Otherwise o_inject=0.
- Every injection is additionally gated by act.
- o_inject_addr is don't-care when o_inject=0. It must still be driven: it takes the jal target.
- Storage is circular: a top pointer tp (log2 RAS_DEPTH bits, wraps) plus the count.
  - Push: tp+1, write entry, count = min(count+1, RAS_DEPTH). On overflow the oldest entry is silently overwritten.
  - Pop: tp−1, count−1.
- i_ex_mispredict: count ← 0. It has priority over any push/pop in the same cycle. tp and entries are left unchanged.
- Reset: tp=0, count=0, all entries 0. o_inject=0 while the inputs are inactive.

## Timing
- Injection has zero latency: combinational from ID inputs and current RAS state.
- RAS updates at the rising edge when enable=1. With enable=0, all state holds; the outputs stay combinational.
- A push in cycle N is visible to a ret in cycle N+1, so back-to-back call/return works.
- Reset asserted mid-operation clears state immediately (async). First updates occur on the first edge after deassertion.
- Simultaneous mispredict and call: the stack is cleared and the push is discarded.

## Test plan
- Reset, then ID jal with pc=0x1000, imm=−8, rd=0: o_inject=1, addr=0xFF8, count stays 0.
- jalr with rs1=0, imm=0x2000, rd=1: inject 0x2000, push 0x(pc+4), count=1. Next cycle jalr rs1=1, rd=0: inject the pushed address, count=0.
- RAS_DEPTH=8, 9 calls with distinct PCs: count saturates at 8. 8 returns pop in LIFO order matching calls 9..2. A 9th return does not inject.
- Compressed call (i_id_compressed=1) at pc=0x400: the next return injects 0x402.
- Call with i_id_flush=1, or call with enable=0: no push, no inject under flush, count unchanged.
- Three pushes, then i_ex_mispredict together with a call: count=0 next cycle. A following return does not inject.
